loadable_counter_5bit: RTL and testbench

// - Free-running 5-bit binary up-counter with synchronous parallel load.
// - Increments on every clock unless reset or load intervenes.
// - Used as a general sequence/timing counter; software/control logic presets it
//   via load/data_in.
//

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_next.sv | 35 +++
 rtl/loadable_counter_5bit.sv | 90 +++++++++
 tb/tb_loadable_counter_5bit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the loadable counter: width, reset value, count type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

    localparam int CNT_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RESET = 5'd0;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Next-state mux for the loadable counter: reset > load > increment.
// Latency: purely combinational, no state.
// Backpressure: none; the result is consumed every cycle by the top register.
//
// Ports:
//   rst_n_i   - synchronous active-low reset request (0 selects RESET_VALUE)
//   load_i    - parallel-load strobe (1 selects data_i)
//   data_i    - value to load
//   count_i   - current registered count
//   next_o    - value the register takes on the next rising edge
module counter_next
    import counter_pkg::*;
#(
    parameter int               WIDTH       = CNT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = CNT_RESET
) (
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] count_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        next_o = count_i + ONE;  // natural wrap from all-ones to zero
        if (!rst_n_i) begin
            next_o = RESET_VALUE;
        end else if (load_i) begin
            next_o = data_i;
        end
    end

endmodule : counter_next

// File: rtl/loadable_counter_5bit.sv
// Free-running binary up-counter with synchronous parallel load.
// Latency: loaded/reset value appears on count one edge after it is sampled.
// Backpressure: none; counts every cycle unless reset or load intervenes.
//
// Ports:
//   clk      - single clock, all updates on rising edge
//   rst      - synchronous active-low reset (0 forces RESET_VALUE)
//   load     - synchronous parallel-load strobe, active-high
//   data_in  - value captured into count when load is high
//   count    - current counter value, straight from the register
module loadable_counter_5bit
    import counter_pkg::*;
#(
    parameter int               WIDTH       = CNT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = CNT_RESET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    counter_next #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_next (
        .rst_n_i (rst),
        .load_i  (load),
        .data_i  (data_in),
        .count_i (count_q),
        .next_o  (count_d)
    );

    // Reset is folded into the next-state mux, so the register is a plain flop.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

`ifndef SYNTHESIS
    // Simulation-only self checks. Each edge records the inputs it sampled;
    // the following edge compares the registered count against what those
    // inputs should have produced. Checks are armed once a reset has been seen,
    // since the power-up value is undefined.
    localparam logic [WIDTH-1:0] ONE_A = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             seen_rst_q;
    logic             chk_q;
    logic             p_rst_q;
    logic             p_load_q;
    logic [WIDTH-1:0] p_data_q;
    logic [WIDTH-1:0] p_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            seen_rst_q <= 1'b1;
        end
        chk_q     <= seen_rst_q || !rst;
        p_rst_q   <= rst;
        p_load_q  <= load;
        p_data_q  <= data_in;
        p_count_q <= count_q;
    end

    always_ff @(posedge clk) begin
        if (chk_q) begin
            assert (!$isunknown(count_q))
                else $error("count is X after reset");
            if (!p_rst_q) begin
                assert (count_q == RESET_VALUE)
                    else $error("reset priority violated: count=%0d", count_q);
            end else if (p_load_q) begin
                assert (count_q == p_data_q)
                    else $error("load capture violated: count=%0d data=%0d",
                                count_q, p_data_q);
            end else begin
                assert (count_q == p_count_q + ONE_A)
                    else $error("increment violated: count=%0d prev=%0d",
                                count_q, p_count_q);
            end
        end
    end
`endif

endmodule : loadable_counter_5bit

// File: tb/tb_loadable_counter_5bit.sv
// Directed bench for loadable_counter_5bit with hand-computed expectations.
// Latency: inputs driven between edges, count sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_loadable_counter_5bit;
    import counter_pkg::*;

    logic clk;
    logic rst;
    logic load;
    cnt_t data_in;
    cnt_t count;

    int checks;
    int failures;

    loadable_counter_5bit dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cnt_t exp_seq [3] = '{5'd1, 5'd2, 5'd3};
        rst = 1'b0; load = 1'b1; data_in = 5'h1B;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (count !== 5'd0) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%0d exp=0", i, count);
            end
        end
        rst = 1'b1; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== exp_seq[i]) begin
                failures++;
                $display("FAIL reset_count[%0d] got=%0d exp=%0d", i, count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_load();
        cnt_t exp_seq [6] = '{5'd28, 5'd29, 5'd30, 5'd31, 5'd0, 5'd1};
        load = 1'b1; data_in = 5'b11011;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== 5'd27) begin
                failures++;
                $display("FAIL load_hold[%0d] got=%0d exp=27", i, count);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (count !== exp_seq[i]) begin
                failures++;
                $display("FAIL load_release[%0d] got=%0d exp=%0d", i, count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        cnt_t exp_seq [3] = '{5'd31, 5'd0, 5'd1};
        load = 1'b1; data_in = 5'b11111;
        step();
        checks++;
        if (count !== exp_seq[0]) begin
            failures++;
            $display("FAIL wrap_load got=%0d exp=%0d", count, exp_seq[0]);
        end
        load = 1'b0;
        for (int i = 1; i < 3; i++) begin
            step();
            checks++;
            if (count !== exp_seq[i]) begin
                failures++;
                $display("FAIL wrap[%0d] got=%0d exp=%0d", i, count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_load_during_count();
        // Count is 1 on entry; eight edges bring it to 9.
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (count !== 5'd9) begin
            failures++;
            $display("FAIL midcount_pre got=%0d exp=9", count);
        end
        load = 1'b1; data_in = 5'd3;
        step();
        checks++;
        if (count !== 5'd3) begin
            failures++;
            $display("FAIL midcount_load got=%0d exp=3", count);
        end
        load = 1'b0;
        step();
        checks++;
        if (count !== 5'd4) begin
            failures++;
            $display("FAIL midcount_resume got=%0d exp=4", count);
        end
    endtask

    task automatic test_back_to_back();
        cnt_t vals [3] = '{5'd5, 5'd10, 5'd20};
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = vals[i];
            step();
            checks++;
            if (count !== vals[i]) begin
                failures++;
                $display("FAIL b2b_load[%0d] got=%0d exp=%0d", i, count, vals[i]);
            end
        end
        load = 1'b0;
        step();
        checks++;
        if (count !== 5'd21) begin
            failures++;
            $display("FAIL b2b_resume got=%0d exp=21", count);
        end
    endtask

    task automatic test_collision();
        rst = 1'b0; load = 1'b1; data_in = 5'd17;
        step();
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL collision got=%0d exp=0", count);
        end
        rst = 1'b1; load = 1'b0;
        step();
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL collision_restart got=%0d exp=1", count);
        end
    endtask

    task automatic test_long_run();
        cnt_t exp_cnt;
        rst = 1'b0; load = 1'b0;
        step();
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL long_reset got=%0d exp=0", count);
        end
        rst = 1'b1;
        exp_cnt = 5'd0;
        for (int i = 1; i <= 64; i++) begin
            step();
            exp_cnt = cnt_t'(i % 32);
            checks++;
            if (count !== exp_cnt) begin
                failures++;
                $display("FAIL long_run[%0d] got=%0d exp=%0d", i, count, exp_cnt);
            end
        end
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL long_final got=%0d exp=0", count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        test_reset();
        test_load();
        test_wrap();
        test_load_during_count();
        test_back_to_back();
        test_collision();
        test_long_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_loadable_counter_5bit
